alu_control_seq: RTL and testbench
==================================

# alu_control_seq

Registered, handshaked successor to the combinational ALU control decoder in the MIPS datapath. It sits between the instruction decode stage and the ALU. It accepts an ALUop/FuncCode pair under a valid/ready handshake and emits a registered ALUCtrl word. Multiply/divide function codes are held for a programmable number of cycles before their control word is released. Unknown R-type function codes produce a defined output and an Illegal flag instead of holding stale state.

## Interface
- OPW, 4: ALUop width.
- CTRLW, 4: ALUCtrl width; minimum 4.
- RTYPE_OP, all ones of OPW: ALUop value that selects FuncCode decoding.
- MC_LAT, 32: cycles from acceptance of a MULT/DIV to out_valid; minimum 2.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- Reset_L  input  1  asynchronous, active-low reset.
- in_valid  input  1  ALUop/FuncCode present.
- in_ready  output  1  block can accept this cycle.
- ALUop  input  OPW  operation class from main control.
- FuncCode  input  6  instruction bits [5:0].
- out_valid  output  1  ALUCtrl/Illegal/MultiCycle are valid.
- out_ready  input  1  ALU consumes the result this cycle.
- ALUCtrl  output  CTRLW  registered ALU control word.
- MultiCycle  output  1  held result came from a MULT/DIV.
- Illegal  output  1  held result came from an undecodable FuncCode.
- Busy  output  1  multi-cycle countdown in progress.

## Operation
- Transfer in: in_valid && in_ready at a rising edge. Transfer out: out_valid && out_ready at a rising edge.
- R-type decode (ALUop == RTYPE_OP), zero-extended to CTRLW:
  - SLL 000000→0011; SRL 000010→0100; SRA 000011→1101.
  - ADD 100000 / ADDU 100001→0010; SUB 100010 / SUBU 100011→0110.
  - AND 100100→0000; OR 100101→0001; XOR 100110→1010; NOR 100111→1100.
  - SLT 101010→0111; SLTU 101011→1000.
  - MULT 011000→1001 and DIV 011010→1011, both multi-cycle.
  - Any other code→ALUCtrl 0, Illegal=1.
- Non-R-type: ALUCtrl = ALUop; truncated to the low CTRLW bits if OPW>CTRLW, zero-extended if OPW<CTRLW. Illegal=0, MultiCycle=0.
- States:
  - IDLE: in_ready=1, out_valid=0.
    - Accepting a single-cycle op moves to VALID.
    - Accepting MULT/DIV loads the counter with MC_LAT-1 and moves to MC.
  - MC: in_ready=0, out_valid=0, Busy=1.
    - The counter decrements each cycle. When the counter reaches 0, move to VALID.
    - in_valid is ignored.
  - VALID: out_valid=1, in_ready=out_ready.
    - Out-transfer with a simultaneous in-transfer: the new op is decoded into the output registers, or enters MC for MULT/DIV. There is no bubble.
    - Out-transfer with no in-transfer: move to IDLE.
    - No out-transfer: all outputs are held stable.
- Output registers load only on an in-transfer. They hold their values otherwise, including in IDLE.

## Timing
- Reset values: ALUCtrl=0, out_valid=0, Illegal=0, MultiCycle=0, Busy=0, state IDLE, counter 0.
- in_ready=0 while Reset_L=0, and 1 from the first cycle after deassertion.
- Reset asserted mid-operation (including during MC) clears all state and outputs immediately, without waiting for a clock edge. A pending result is discarded.
- Single-cycle op latency: out_valid rises one cycle after the in-transfer edge.
- MULT/DIV latency: out_valid rises exactly MC_LAT cycles after the in-transfer edge.
- Throughput: one op per cycle while out_ready=1 and no MULT/DIV is in progress.
- Counter width is $clog2(MC_LAT). The counter never wraps: it loads only from IDLE or VALID, and decrements only in MC.

## Configuration
- ALUCTRL_MC_EN defined:
  - MULT/DIV decode as described, with MultiCycle=1 and the MC state present.
- ALUCTRL_MC_EN undefined:
  - MC state and counter are not built.
  - 011000 and 011010 decode as Illegal with ALUCtrl=0.
  - Busy and MultiCycle are tied to 0.
  - All other behaviour is identical.

## Test plan
- Reset: Reset_L=0 mid-MC countdown → all outputs 0 immediately; in_ready=1 on the first edge after release.
- R-type sweep: ALUop=1111 with each listed FuncCode, out_ready=1 → ALUCtrl matches the table one cycle later; e.g. 100010→0110, 000011→1101.
- Back-to-back with stall: ADD, SUB, OR on consecutive cycles with out_ready held 0 for two cycles after the first result → ADD result is held stable; in_ready=0 during the stall; results emerge in order 0010, 0110, 0001 with no loss.
- Illegal: FuncCode 111111 → ALUCtrl=0000, Illegal=1, out_valid one cycle later. Next op SLT → Illegal=0, ALUCtrl=0111.
- Multi-cycle (MC_LAT=4, ALUCTRL_MC_EN defined): MULT accepted at cycle t → Busy=1 for cycles t+1..t+3; in_ready=0 there; out_valid=1 with ALUCtrl=1001 and MultiCycle=1 at t+4. Rebuilt without the macro → Illegal=1 at t+1.
- Passthrough: OPW=6, ALUop=6'b110010 (non R-type) → ALUCtrl=0010, Illegal=0.

Source files
------------

// File: rtl/alu_control_seq.sv
// alu_control_seq
//   Registered, handshaked ALU control decoder. It takes an ALUop/FuncCode
//   pair from decode under valid/ready and presents a registered ALUCtrl
//   word to the ALU under a second valid/ready pair. MULT/DIV codes are
//   held for MC_LAT cycles before out_valid rises. Undecodable R-type codes
//   produce ALUCtrl=0 with Illegal=1.
//
//   Optional feature macro: ALUCTRL_MC_EN
//     defined   : MULT/DIV are multi-cycle (MultiCycle=1, countdown state).
//     undefined : MULT/DIV decode as Illegal, Busy/MultiCycle tied to 0.
//
//   Ports
//     CLK        in   clock, rising edge
//     Reset_L    in   asynchronous active-low reset
//     in_valid   in   ALUop/FuncCode present
//     in_ready   out  block can accept this cycle
//     ALUop      in   [OPW-1:0] operation class from main control
//     FuncCode   in   [5:0] instruction function field
//     out_valid  out  ALUCtrl/Illegal/MultiCycle valid
//     out_ready  in   ALU consumes the result this cycle
//     ALUCtrl    out  [CTRLW-1:0] registered ALU control word
//     MultiCycle out  held result came from MULT/DIV
//     Illegal    out  held result came from an undecodable FuncCode
//     Busy       out  multi-cycle countdown in progress
module alu_control_seq #(
  parameter int              OPW      = 4,
  parameter int              CTRLW    = 4,
  parameter logic [OPW-1:0]  RTYPE_OP = {OPW{1'b1}},
  parameter int              MC_LAT   = 32
) (
  input  logic             CLK,
  input  logic             Reset_L,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   ALUop,
  input  logic [5:0]       FuncCode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CTRLW-1:0] ALUCtrl,
  output logic             MultiCycle,
  output logic             Illegal,
  output logic             Busy
);

  // Elaboration-time guard on parameter ranges.
  if (CTRLW < 4 || MC_LAT < 2) begin : g_param_check
    $error("alu_control_seq: CTRLW must be >= 4 and MC_LAT must be >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_VALID = 2'd1
`ifdef ALUCTRL_MC_EN
    ,
    S_MC    = 2'd2
`endif
  } state_t;

  // Returns {illegal, ctrl}. MULT/DIV only decode when the multi-cycle
  // path exists; otherwise they fall into the illegal default.
  function automatic logic [CTRLW:0] decode(input logic [OPW-1:0] op,
                                            input logic [5:0]     fc);
    logic [3:0] c;
    logic       ill;
    c   = 4'b0000;
    ill = 1'b0;
    if (op == RTYPE_OP) begin
      case (fc)
        6'b000000: c = 4'b0011;  // SLL
        6'b000010: c = 4'b0100;  // SRL
        6'b000011: c = 4'b1101;  // SRA
        6'b100000,
        6'b100001: c = 4'b0010;  // ADD/ADDU
        6'b100010,
        6'b100011: c = 4'b0110;  // SUB/SUBU
        6'b100100: c = 4'b0000;  // AND
        6'b100101: c = 4'b0001;  // OR
        6'b100110: c = 4'b1010;  // XOR
        6'b100111: c = 4'b1100;  // NOR
        6'b101010: c = 4'b0111;  // SLT
        6'b101011: c = 4'b1000;  // SLTU
`ifdef ALUCTRL_MC_EN
        6'b011000: c = 4'b1001;  // MULT
        6'b011010: c = 4'b1011;  // DIV
`endif
        default:   ill = 1'b1;
      endcase
      return {ill, CTRLW'(c)};
    end
    return {1'b0, CTRLW'(op)};
  endfunction

  state_t           state_reg;
  logic             run_reg;        // low in reset, high from the first edge after release
  logic [CTRLW-1:0] ctrl_reg;
  logic             illegal_reg;
  logic             out_valid_reg;
  logic [CTRLW:0]   dec;
  logic [CTRLW-1:0] dec_ctrl;
  logic             dec_ill;
  logic             in_fire;
  logic             out_fire;

  assign dec      = decode(ALUop, FuncCode);
  assign dec_ctrl = dec[CTRLW-1:0];
  assign dec_ill  = dec[CTRLW];

  // Ready when empty, or when the held result leaves this same cycle.
  assign in_ready = run_reg &&
                    ((state_reg == S_IDLE) || ((state_reg == S_VALID) && out_ready));
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_reg && out_ready;

`ifdef ALUCTRL_MC_EN
  localparam int CNTW = $clog2(MC_LAT);

  logic [CNTW-1:0] cnt_reg;
  logic            mc_reg;
  logic            busy_reg;
  logic            dec_mc;

  assign dec_mc = (ALUop == RTYPE_OP) &&
                  ((FuncCode == 6'b011000) || (FuncCode == 6'b011010));
`endif

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_reg     <= S_IDLE;
      run_reg       <= 1'b0;
      ctrl_reg      <= '0;
      illegal_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
`ifdef ALUCTRL_MC_EN
      cnt_reg       <= '0;
      mc_reg        <= 1'b0;
      busy_reg      <= 1'b0;
`endif
    end else begin
      run_reg <= 1'b1;
      case (state_reg)
        S_IDLE, S_VALID: begin
          if (in_fire) begin
            ctrl_reg    <= dec_ctrl;
            illegal_reg <= dec_ill;
`ifdef ALUCTRL_MC_EN
            mc_reg      <= dec_mc;
            if (dec_mc) begin
              state_reg     <= S_MC;
              out_valid_reg <= 1'b0;
              busy_reg      <= 1'b1;
              cnt_reg       <= CNTW'(MC_LAT - 1);
            end else begin
              state_reg     <= S_VALID;
              out_valid_reg <= 1'b1;
            end
`else
            state_reg     <= S_VALID;
            out_valid_reg <= 1'b1;
`endif
          end else if (out_fire) begin
            state_reg     <= S_IDLE;
            out_valid_reg <= 1'b0;
          end
        end
`ifdef ALUCTRL_MC_EN
        // The counter is loaded with MC_LAT-1 >= 1, so the edge on which it
        // reaches 0 is also the edge that releases the result; it cannot wrap.
        S_MC: begin
          cnt_reg <= cnt_reg - 1'b1;
          if (cnt_reg == CNTW'(1)) begin
            state_reg     <= S_VALID;
            out_valid_reg <= 1'b1;
            busy_reg      <= 1'b0;
          end
        end
`endif
        default: begin
          state_reg     <= S_IDLE;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign ALUCtrl   = ctrl_reg;
  assign Illegal   = illegal_reg;
  assign out_valid = out_valid_reg;
`ifdef ALUCTRL_MC_EN
  assign MultiCycle = mc_reg;
  assign Busy       = busy_reg;
`else
  assign MultiCycle = 1'b0;
  assign Busy       = 1'b0;
`endif

endmodule

// File: tb/tb_alu_control_seq.sv
module tb_alu_control_seq;

  localparam int LAT = 4;

  logic       CLK = 1'b0;
  logic       Reset_L;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [3:0] ALUop;
  logic [5:0] FuncCode;
  logic [3:0] ALUCtrl;
  logic       MultiCycle, Illegal, Busy;

  // Second instance: wide ALUop to exercise truncation.
  logic       in_valid2, in_ready2, out_valid2, out_ready2;
  logic [5:0] ALUop2;
  logic [5:0] FuncCode2;
  logic [3:0] ALUCtrl2;
  logic       MultiCycle2, Illegal2, Busy2;

  always #5 CLK = ~CLK;

  alu_control_seq #(.OPW(4), .CTRLW(4), .MC_LAT(LAT)) dut (
    .CLK(CLK), .Reset_L(Reset_L),
    .in_valid(in_valid), .in_ready(in_ready),
    .ALUop(ALUop), .FuncCode(FuncCode),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALUCtrl(ALUCtrl), .MultiCycle(MultiCycle),
    .Illegal(Illegal), .Busy(Busy)
  );

  alu_control_seq #(.OPW(6), .CTRLW(4), .MC_LAT(LAT)) dut6 (
    .CLK(CLK), .Reset_L(Reset_L),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .ALUop(ALUop2), .FuncCode(FuncCode2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .ALUCtrl(ALUCtrl2), .MultiCycle(MultiCycle2),
    .Illegal(Illegal2), .Busy(Busy2)
  );

  typedef struct {
    logic [3:0] ctrl;
    logic       ill;
    logic       mc;
    int         acc;   // cycle index of the accepting edge
    int         lat;   // cycles from acceptance to visible out_valid
  } item_t;

  item_t q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  int    n_in   = 0;
  int    n_out  = 0;

  logic [5:0] fcs [16] = '{6'd0, 6'd2, 6'd3, 6'd32, 6'd33, 6'd34, 6'd35, 6'd36,
                           6'd37, 6'd38, 6'd39, 6'd42, 6'd43, 6'd24, 6'd26, 6'd63};

  // Reference: the decode table and latency rule as plain lookups.
  function automatic item_t ref_item(input logic [3:0] op, input logic [5:0] fc);
    item_t it;
    it.ctrl = op; it.ill = 1'b0; it.mc = 1'b0; it.acc = 0; it.lat = 1;
    if (op == 4'hF) begin
      it.ctrl = 4'h0;
      case (fc)
        6'd0:  it.ctrl = 4'd3;
        6'd2:  it.ctrl = 4'd4;
        6'd3:  it.ctrl = 4'd13;
        6'd32, 6'd33: it.ctrl = 4'd2;
        6'd34, 6'd35: it.ctrl = 4'd6;
        6'd36: it.ctrl = 4'd0;
        6'd37: it.ctrl = 4'd1;
        6'd38: it.ctrl = 4'd10;
        6'd39: it.ctrl = 4'd12;
        6'd42: it.ctrl = 4'd7;
        6'd43: it.ctrl = 4'd8;
`ifdef ALUCTRL_MC_EN
        6'd24: begin it.ctrl = 4'd9;  it.mc = 1'b1; it.lat = LAT; end
        6'd26: begin it.ctrl = 4'd11; it.mc = 1'b1; it.lat = LAT; end
`endif
        default: it.ill = 1'b1;
      endcase
    end
    return it;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle of the main instance: drive, check against the model, clock, update.
  task automatic step(input logic iv, input logic [3:0] op, input logic [5:0] fc, input logic ordy);
    logic  exp_ov, exp_rdy, exp_busy, in_f, out_f;
    item_t it;
    in_valid = iv; ALUop = op; FuncCode = fc; out_ready = ordy;
    #1;
    exp_ov   = (q.size() > 0) && ((cyc - q[0].acc) >= (q[0].lat - 1));
    exp_busy = (q.size() > 0) && !exp_ov;
    exp_rdy  = (q.size() == 0) || (exp_ov && ordy);
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    check("in_ready",  32'(in_ready),  32'(exp_rdy));
    check("busy",      32'(Busy),      32'(exp_busy));
    if (exp_ov) begin
      check("aluctrl",    32'(ALUCtrl),    32'(q[0].ctrl));
      check("illegal",    32'(Illegal),    32'(q[0].ill));
      check("multicycle", 32'(MultiCycle), 32'(q[0].mc));
    end
    in_f  = iv && exp_rdy;
    out_f = exp_ov && ordy;
    if (out_f)
      $display("out  #%0d ctrl=%b illegal=%b multicycle=%b cycle=%0d",
               n_out, ALUCtrl, Illegal, MultiCycle, cyc);
    @(posedge CLK);
    #1;
    cyc++;
    if (out_f) begin void'(q.pop_front()); n_out++; end
    if (in_f) begin
      it = ref_item(op, fc);
      it.acc = cyc;
      q.push_back(it);
      n_in++;
    end
  endtask

  initial begin
    Reset_L = 1'b0;
    in_valid = 1'b0; ALUop = 4'h0; FuncCode = 6'h0; out_ready = 1'b0;
    in_valid2 = 1'b0; ALUop2 = 6'h0; FuncCode2 = 6'h0; out_ready2 = 1'b0;

    // Reset state
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_aluctrl",   32'(ALUCtrl),   32'd0);
    check("rst_illegal",   32'(Illegal),   32'd0);
    check("rst_mc",        32'(MultiCycle),32'd0);
    check("rst_busy",      32'(Busy),      32'd0);
    #6 Reset_L = 1'b1;
    @(posedge CLK); #1; cyc++;
    check("rdy_after_rst", 32'(in_ready), 32'd1);

    // Passthrough on the wide instance
    in_valid2 = 1'b1; ALUop2 = 6'b110010; out_ready2 = 1'b1;
    step(1'b0, 4'h0, 6'h0, 1'b1);
    check("pt_valid",   32'(out_valid2), 32'd1);
    check("pt_ctrl",    32'(ALUCtrl2),   32'b0010);
    check("pt_illegal", 32'(Illegal2),   32'd0);
    ALUop2 = 6'b001111;
    step(1'b0, 4'h0, 6'h0, 1'b1);
    check("pt_trunc", 32'(ALUCtrl2), 32'b1111);
    ALUop2 = 6'h3F; FuncCode2 = 6'b100010;
    step(1'b0, 4'h0, 6'h0, 1'b1);
    check("w_rtype_sub", 32'(ALUCtrl2), 32'b0110);
    check("w_rtype_ill", 32'(Illegal2), 32'd0);
    in_valid2 = 1'b0;

    // R-type sweep, back to back, including the illegal and multi-cycle codes
    for (int i = 0; i < 16; i++) step(1'b1, 4'hF, fcs[i], 1'b1);
    for (int i = 0; i < LAT + 1; i++) step(1'b0, 4'h0, 6'h0, 1'b1);

    // Back-to-back with a two-cycle stall after the first result
    step(1'b1, 4'hF, 6'b100000, 1'b1);   // ADD accepted
    step(1'b1, 4'hF, 6'b100010, 1'b0);   // stall: held, not accepted
    step(1'b1, 4'hF, 6'b100010, 1'b0);
    step(1'b1, 4'hF, 6'b100010, 1'b1);   // SUB accepted, ADD leaves
    step(1'b1, 4'hF, 6'b100101, 1'b1);   // OR
    step(1'b0, 4'h0, 6'h0, 1'b1);
    step(1'b0, 4'h0, 6'h0, 1'b1);

    // Illegal then SLT
    step(1'b1, 4'hF, 6'b111111, 1'b1);
    step(1'b1, 4'hF, 6'b101010, 1'b1);
    step(1'b0, 4'h0, 6'h0, 1'b1);

    // Non-R-type passthrough on the main instance
    step(1'b1, 4'h5, 6'h3F, 1'b1);
    step(1'b0, 4'h0, 6'h0, 1'b1);

    // MULT, then reset in the middle of the countdown
    step(1'b1, 4'hF, 6'b011000, 1'b1);
    step(1'b0, 4'h0, 6'h0, 1'b1);
    #3 Reset_L = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy",      32'(Busy),      32'd0);
    check("mid_rst_mc",        32'(MultiCycle),32'd0);
    check("mid_rst_aluctrl",   32'(ALUCtrl),   32'd0);
    check("mid_rst_illegal",   32'(Illegal),   32'd0);
    check("mid_rst_in_ready",  32'(in_ready),  32'd0);
    q.delete();
    #2 Reset_L = 1'b1;
    @(posedge CLK); #1; cyc++;
    check("rdy_after_mid_rst", 32'(in_ready), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [3:0] op;
      logic [5:0] fc;
      op = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
      fc = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fcs[$urandom_range(0, 15)];
      step($urandom_range(0, 3) != 0, op, fc, $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < LAT + 2; i++) step(1'b0, 4'h0, 6'h0, 1'b1);

    check("drained",      32'(q.size()), 32'd0);
    check("in_out_count", 32'(n_out),    32'(n_in));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
